// File: rtl/riscv_rvalid_stall.sv
// OBI response-phase staller: queues memory responses in order and releases each
// to the core once its per-entry delay has elapsed at the head of the queue.
module riscv_rvalid_stall #(
  parameter int DEPTH      = 4,
  parameter int DATA_WIDTH = 32
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         rvalid_mem_i,
  input  logic [DATA_WIDTH-1:0]        rdata_mem_i,
  input  logic                         err_mem_i,
  output logic                         rvalid_core_o,
  output logic [DATA_WIDTH-1:0]        rdata_core_o,
  output logic                         err_core_o,
  input  logic                         en_stall_i,
  input  logic [31:0]                  stall_mode_i,
  input  logic [31:0]                  max_stall_i,
  input  logic [31:0]                  rvalid_stall_i,
  output logic [$clog2(DEPTH+1)-1:0]   count_o,
  output logic                         overflow_o
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [31:0] STANDARD = 32'd0;
  localparam logic [31:0] RANDOM   = 32'd1;

  logic [DATA_WIDTH-1:0] data_q [DEPTH];
  logic                  err_q  [DEPTH];
  logic [31:0]           dly_q  [DEPTH];
  logic [PW-1:0]         wptr, rptr;
  logic [CW-1:0]         count;
  logic [31:0]           timer, dly_in;
  logic                  overflow, head_valid, pop, push, full;

  function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH-1)) ? '0 : p + PW'(1);
  endfunction

  // RANDOM draws from the simulator RNG; a synthesized build sees delay 0 there.
  always_comb begin
    dly_in = '0;
    if (en_stall_i) begin
      if (stall_mode_i == STANDARD) dly_in = rvalid_stall_i;
`ifndef SYNTHESIS
      else if (stall_mode_i == RANDOM) dly_in = $urandom_range(max_stall_i, 0);
`endif
    end
  end

  assign head_valid    = (count != '0);
  assign pop           = head_valid && (timer == '0);
  assign full          = (count == CW'(DEPTH));
  assign push          = rvalid_mem_i && (!full || pop);
  assign rvalid_core_o = pop;
  assign rdata_core_o  = pop ? data_q[rptr] : '0;
  assign err_core_o    = pop & err_q[rptr];
  assign count_o       = count;
  assign overflow_o    = overflow;

  always_ff @(posedge clk_i) begin
    if (push) begin
      data_q[wptr] <= rdata_mem_i;
      err_q[wptr]  <= err_mem_i;
      dly_q[wptr]  <= dly_in;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wptr     <= '0;
      rptr     <= '0;
      count    <= '0;
      timer    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wptr <= inc(wptr);
      if (pop)  rptr <= inc(rptr);
      if (push && !pop)      count <= count + CW'(1);
      else if (pop && !push) count <= count - CW'(1);
      if (rvalid_mem_i && !push) overflow <= 1'b1;
      // Timer is reloaded whenever a new entry reaches the head.
      if (pop) begin
        if (count > CW'(1)) timer <= dly_q[inc(rptr)];
        else if (push)      timer <= dly_in;
      end else if (!head_valid) begin
        if (push) timer <= dly_in;
      end else if (timer != '0) begin
        timer <= timer - 32'd1;
      end
    end
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk_i) begin
    if (rst_ni && rvalid_mem_i && !push)
      $warning("riscv_rvalid_stall: response dropped, queue full");
  end
`endif

endmodule

// File: tb/tb_riscv_rvalid_stall.sv
// Bench for riscv_rvalid_stall: directed scenarios plus random traffic against a
// delivery-schedule model (delivery = max(arrival, prev delivery) + 1 + D).
module tb_riscv_rvalid_stall;
  localparam int DEPTH = 4;
  localparam int DW    = 32;
  localparam int CW    = $clog2(DEPTH+1);
  localparam logic [31:0] STANDARD = 32'd0;
  localparam logic [31:0] RANDOM   = 32'd1;

  logic          clk = 1'b0, rst_n = 1'b0;
  logic          rvalid_mem_i = 1'b0, err_mem_i = 1'b0, en_stall_i = 1'b0;
  logic [DW-1:0] rdata_mem_i = '0;
  logic [31:0]   stall_mode_i = '0, max_stall_i = '0, rvalid_stall_i = '0;
  logic          rvalid_core_o, err_core_o, overflow_o;
  logic [DW-1:0] rdata_core_o;
  logic [CW-1:0] count_o;

  riscv_rvalid_stall #(.DEPTH(DEPTH), .DATA_WIDTH(DW)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .rvalid_mem_i(rvalid_mem_i), .rdata_mem_i(rdata_mem_i), .err_mem_i(err_mem_i),
    .rvalid_core_o(rvalid_core_o), .rdata_core_o(rdata_core_o), .err_core_o(err_core_o),
    .en_stall_i(en_stall_i), .stall_mode_i(stall_mode_i), .max_stall_i(max_stall_i),
    .rvalid_stall_i(rvalid_stall_i), .count_o(count_o), .overflow_o(overflow_o)
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0;
  longint cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  typedef struct {
    logic [31:0] data;
    logic        err;
    longint      arr;
    longint      deliv;
    bit          rnd;
  } ent_t;

  ent_t   q[$];
  ent_t   e;
  longint last_deliv = -1, lat, d;
  bit     ovf_m = 0, mon_en = 0, exp_pop, pop_now, front_ok;
  int     occ, rnd_n = 0;
  longint rnd_min = 1000, rnd_max = 0;

  // Reference model, evaluated mid-cycle on the falling edge.
  always @(negedge clk) begin
    if (mon_en) begin
      occ = 0;
      foreach (q[i]) if (q[i].arr < cyc) occ++;
      front_ok = (q.size() > 0) && (q[0].arr < cyc);
      chk("count", 64'(count_o), 64'(occ));
      chk("overflow", 64'(overflow_o), 64'(ovf_m));
      pop_now = 0;
      if (front_ok && q[0].rnd) begin
        if (rvalid_core_o) begin
          lat = cyc - q[0].arr;
          chk("rnd_lat_in_range", 64'(lat >= 1 && lat <= 6), 64'd1);
          chk("rnd_data", 64'(rdata_core_o), 64'(q[0].data));
          chk("rnd_err", 64'(err_core_o), 64'(q[0].err));
          if (lat < rnd_min) rnd_min = lat;
          if (lat > rnd_max) rnd_max = lat;
          rnd_n++;
          void'(q.pop_front());
          pop_now = 1;
        end else begin
          chk("rnd_late", 64'(cyc - q[0].arr >= 6), 64'd0);
        end
      end else begin
        exp_pop = front_ok && (q[0].deliv == cyc);
        chk("rvalid", 64'(rvalid_core_o), 64'(exp_pop));
        if (exp_pop) begin
          chk("data", 64'(rdata_core_o), 64'(q[0].data));
          chk("err", 64'(err_core_o), 64'(q[0].err));
          void'(q.pop_front());
          pop_now = 1;
        end
      end
      if (!rvalid_core_o) chk("idle_out", {31'd0, err_core_o, rdata_core_o}, 64'd0);
    end
    if (!rst_n) begin
      q.delete();
      ovf_m = 0;
      last_deliv = -1;
    end else if (rvalid_mem_i) begin
      if (occ == DEPTH && !pop_now) ovf_m = 1;
      else begin
        e.data = rdata_mem_i;
        e.err  = err_mem_i;
        e.arr  = cyc;
        e.rnd  = en_stall_i && (stall_mode_i == RANDOM);
        d      = (en_stall_i && stall_mode_i == STANDARD) ? longint'(rvalid_stall_i) : 0;
        e.deliv = ((cyc > last_deliv) ? cyc : last_deliv) + 1 + d;
        last_deliv = e.rnd ? cyc + 7 : e.deliv;
        q.push_back(e);
      end
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    rvalid_mem_i = 1'b0;
    repeat (n) step();
  endtask

  task automatic send(input logic [31:0] dat, input logic er);
    rvalid_mem_i = 1'b1; rdata_mem_i = dat; err_mem_i = er;
    step();
    rvalid_mem_i = 1'b0; err_mem_i = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    step();
    mon_en = 1;
    step();
    rst_n = 1'b1;
    chk("rst_count", 64'(count_o), 64'd0);
    chk("rst_rvalid", 64'(rvalid_core_o), 64'd0);
    chk("rst_rdata", 64'(rdata_core_o), 64'd0);
    chk("rst_ovf", 64'(overflow_o), 64'd0);

    // pass-through
    idle(3);
    send(32'hA5A5_0001, 1'b0);
    chk("pt_rvalid", 64'(rvalid_core_o), 64'd1);
    chk("pt_rdata", 64'(rdata_core_o), 64'hA5A5_0001);
    step();
    chk("pt_rvalid_once", 64'(rvalid_core_o), 64'd0);
    chk("pt_count", 64'(count_o), 64'd0);
    idle(3);

    // STANDARD delay 3
    en_stall_i = 1'b1; stall_mode_i = STANDARD; rvalid_stall_i = 32'd3;
    send(32'h0000_0BEE, 1'b0);
    for (int i = 0; i < 3; i++) begin
      chk("std_wait", 64'(rvalid_core_o), 64'd0);
      step();
    end
    chk("std_deliver", 64'(rvalid_core_o), 64'd1);
    idle(4);

    // ordering with delay 2, error on the middle response
    rvalid_stall_i = 32'd2;
    send(32'h1, 1'b0); send(32'h2, 1'b1); send(32'h3, 1'b0);
    idle(12);

    // full and overflow
    rvalid_stall_i = 32'd20;
    for (int i = 0; i < 5; i++) send(32'h100 + 32'(i), 1'b0);
    chk("full_count", 64'(count_o), 64'd4);
    chk("full_ovf", 64'(overflow_o), 64'd1);
    idle(100);
    chk("ovf_sticky", 64'(overflow_o), 64'd1);
    do_reset();
    chk("ovf_cleared", 64'(overflow_o), 64'd0);

    // fifth response lands in a pop cycle
    rvalid_stall_i = 32'd3;
    send(32'h200, 1'b0);
    rvalid_stall_i = 32'd20;
    for (int i = 1; i < 5; i++) send(32'h200 + 32'(i), 1'b0);
    chk("popcyc_ovf", 64'(overflow_o), 64'd0);
    chk("popcyc_count", 64'(count_o), 64'd4);
    idle(100);

    // reset with three entries pending
    for (int i = 0; i < 3; i++) send(32'h300 + 32'(i), 1'b0);
    idle(2);
    do_reset();
    chk("mid_rst_count", 64'(count_o), 64'd0);
    for (int i = 0; i < 30; i++) begin
      chk("mid_rst_quiet", 64'(rvalid_core_o), 64'd0);
      step();
    end
    chk("mid_rst_ovf", 64'(overflow_o), 64'd0);

    // random mixed traffic with fixed/other/disabled delays
    repeat (300) begin
      en_stall_i     = ($urandom_range(3) != 0);
      stall_mode_i   = ($urandom_range(3) == 0) ? 32'd7 : STANDARD;
      rvalid_stall_i = $urandom_range(6);
      rvalid_mem_i   = ($urandom_range(99) < 45);
      rdata_mem_i    = $urandom;
      err_mem_i      = 1'($urandom_range(1));
      step();
    end
    idle(80);
    do_reset();

    // RANDOM mode
    en_stall_i = 1'b1; stall_mode_i = RANDOM; max_stall_i = 32'd5;
    for (int i = 0; i < 200; i++) begin
      send($urandom, 1'($urandom_range(1)));
      idle(7);
    end
    idle(10);
    chk("rnd_count", 64'(rnd_n), 64'd200);
    chk("rnd_min", 64'(rnd_min), 64'd1);
    chk("rnd_max", 64'(rnd_max), 64'd6);
    chk("rnd_ovf", 64'(overflow_o), 64'd0);
    chk("drained", 64'(q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
